// File: rtl/dport_pkg.sv
// rtl/dport_pkg.sv - shared FSM state, funct3 codes and access-size helper for the data port
package dport_pkg;

  typedef enum logic [1:0] {IDLE, REQ, RDWAIT, DONE} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] ERR_FILL = 32'hFFFF_FFFF;

  // Stores only define SB/SH/SW; every code outside the legal set acts as a word.
  function automatic size_e access_size(input logic is_load, input logic [2:0] f3);
    size_e sz;
    sz = SZ_W;
    if (is_load) begin
      if (f3 == F3_B || f3 == F3_BU) sz = SZ_B;
      else if (f3 == F3_H || f3 == F3_HU) sz = SZ_H;
    end else begin
      if (f3 == F3_B) sz = SZ_B;
      else if (f3 == F3_H) sz = SZ_H;
    end
    return sz;
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - load lane select with sign/zero extension, and store byteenable/writedata lane generator
module load_align
  import dport_pkg::*;
(
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_raw_i,
  output logic [31:0] ld_data_o,
  input  logic        req_load_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [1:0]  req_off_i,
  input  logic [31:0] req_wdata_i,
  output logic [3:0]  req_be_o,
  output logic [31:0] req_wdata_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_signed;

  always_comb begin
    ld_byte   = ld_raw_i[{ld_off_i, 3'b000} +: 8];
    ld_half   = ld_raw_i[{ld_off_i[1], 4'b0000} +: 16];
    ld_signed = ~ld_funct3_i[2];
    case (access_size(1'b1, ld_funct3_i))
      SZ_B:    ld_data_o = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      SZ_H:    ld_data_o = {{16{ld_signed & ld_half[15]}}, ld_half};
      default: ld_data_o = ld_raw_i;
    endcase
  end

  // Shift amounts ignore the sub-size offset bits, which aligns misaligned accesses.
  always_comb begin
    case (access_size(req_load_i, req_funct3_i))
      SZ_B: begin
        req_be_o    = 4'b0001 << req_off_i;
        req_wdata_o = {4{req_wdata_i[7:0]}};
      end
      SZ_H: begin
        req_be_o    = 4'b0011 << {req_off_i[1], 1'b0};
        req_wdata_o = {2{req_wdata_i[15:0]}};
      end
      default: begin
        req_be_o    = 4'b1111;
        req_wdata_o = req_wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/avalon_data_port.sv
// rtl/avalon_data_port.sv - Avalon-MM data-memory master with pipeline stall gating; MISALIGN_TRAP_EN traps misaligned H/W accesses
module avalon_data_port
  import dport_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int N_STAGES = 4,
  parameter int TIMEOUT  = 0
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                mem_rd,
  input  logic                mem_wr,
  input  logic [2:0]          funct3,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [31:0]         wdata,
  input  logic [N_STAGES-1:0] enable_in,
  input  logic                enable_pc_in,
  output logic [N_STAGES-1:0] enable_out,
  output logic                enable_pc_out,
  output logic [31:0]         rdata,
  output logic                busy,
  output logic                err,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [3:0]          avm_byteenable,
  output logic [31:0]         avm_writedata,
  input  logic [31:0]         avm_readdata,
  input  logic                avm_waitrequest,
  input  logic                avm_readdatavalid
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e            state_q;
  logic              rd_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] avm_address_q;
  logic              avm_read_q;
  logic              avm_write_q;
  logic [3:0]        avm_byteenable_q;
  logic [31:0]       avm_writedata_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic        req;
  logic        is_load;
  logic        trap;
  logic        wdog_hit;
  logic        pass;
  logic [31:0] ld_data;
  logic [3:0]  be_d;
  logic [31:0] wd_d;

  assign req     = mem_rd | mem_wr;
  assign is_load = mem_rd;

`ifdef MISALIGN_TRAP_EN
  size_e req_size;
  assign req_size = access_size(is_load, funct3);
  assign trap = ((req_size == SZ_H) && addr[0]) ||
                ((req_size == SZ_W) && (addr[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  assign wdog_hit = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

  load_align u_load_align (
    .ld_funct3_i  (f3_q),
    .ld_off_i     (off_q),
    .ld_raw_i     (avm_readdata),
    .ld_data_o    (ld_data),
    .req_load_i   (is_load),
    .req_funct3_i (funct3),
    .req_off_i    (addr[1:0]),
    .req_wdata_i  (wdata),
    .req_be_o     (be_d),
    .req_wdata_o  (wd_d)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q          <= IDLE;
      rd_q             <= 1'b0;
      f3_q             <= 3'b000;
      off_q            <= 2'b00;
      cnt_q            <= '0;
      avm_address_q    <= '0;
      avm_read_q       <= 1'b0;
      avm_write_q      <= 1'b0;
      avm_byteenable_q <= 4'b0000;
      avm_writedata_q  <= 32'd0;
      rdata_q          <= 32'd0;
      err_q            <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            rd_q <= is_load;
            if (trap) begin
              state_q <= DONE;
              err_q   <= 1'b1;
              if (is_load) rdata_q <= 32'd0;
            end else begin
              state_q          <= REQ;
              avm_read_q       <= is_load;
              avm_write_q      <= ~is_load;
              avm_address_q    <= {addr[ADDR_W-1:2], 2'b00};
              avm_byteenable_q <= be_d;
              avm_writedata_q  <= wd_d;
              f3_q             <= funct3;
              off_q            <= addr[1:0];
              cnt_q            <= '0;
            end
          end
        end
        REQ: begin
          if (!avm_waitrequest) begin
            avm_read_q  <= 1'b0;
            avm_write_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= rd_q ? RDWAIT : DONE;
          end else if (wdog_hit) begin
            avm_read_q  <= 1'b0;
            avm_write_q <= 1'b0;
            err_q       <= 1'b1;
            if (rd_q) rdata_q <= ERR_FILL;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RDWAIT: begin
          if (avm_readdatavalid) begin
            rdata_q <= ld_data;
            state_q <= DONE;
          end else if (wdog_hit) begin
            rdata_q <= ERR_FILL;
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // The stage that owns the access may only advance once the access has finished.
  assign pass          = (state_q == DONE) || ((state_q == IDLE) && !req);
  assign enable_out    = pass ? enable_in : '0;
  assign enable_pc_out = pass & enable_pc_in;

  assign busy           = (state_q != IDLE);
  assign err            = err_q;
  assign rdata          = rdata_q;
  assign avm_address    = avm_address_q;
  assign avm_read       = avm_read_q;
  assign avm_write      = avm_write_q;
  assign avm_byteenable = avm_byteenable_q;
  assign avm_writedata  = avm_writedata_q;

endmodule

// File: tb/tb_avalon_data_port.sv
// tb/tb_avalon_data_port.sv - directed self-checking bench for avalon_data_port
module tb_avalon_data_port;
  import dport_pkg::*;

  localparam int ADDR_W   = 32;
  localparam int N_STAGES = 4;
  localparam int TIMEOUT  = 8;

  logic                CLK = 1'b0;
  logic                RST_N = 1'b0;
  logic                mem_rd, mem_wr;
  logic [2:0]          funct3;
  logic [ADDR_W-1:0]   addr;
  logic [31:0]         wdata;
  logic [N_STAGES-1:0] enable_in;
  logic                enable_pc_in;
  logic [N_STAGES-1:0] enable_out;
  logic                enable_pc_out;
  logic [31:0]         rdata;
  logic                busy, err;
  logic [ADDR_W-1:0]   avm_address;
  logic                avm_read, avm_write;
  logic [3:0]          avm_byteenable;
  logic [31:0]         avm_writedata;
  logic [31:0]         avm_readdata;
  logic                avm_waitrequest, avm_readdatavalid;

  int errors = 0;
  int checks = 0;

  bit          chk_en = 1'b0;
  bit          exp_pass, exp_busy, exp_rd, exp_wr, exp_err;
  logic [31:0] exp_addr, exp_wd, rdata_m;
  logic [3:0]  exp_be;
  logic [31:0] last_addr, last_wd;
  logic [3:0]  last_be;

  avalon_data_port #(.ADDR_W(ADDR_W), .N_STAGES(N_STAGES), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST_N(RST_N), .mem_rd(mem_rd), .mem_wr(mem_wr), .funct3(funct3),
    .addr(addr), .wdata(wdata), .enable_in(enable_in), .enable_pc_in(enable_pc_in),
    .enable_out(enable_out), .enable_pc_out(enable_pc_out), .rdata(rdata), .busy(busy),
    .err(err), .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic int size_of(input bit ld, input logic [2:0] f3);
    if (ld) return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    return (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
  endfunction

  function automatic int off_of(input int n, input logic [31:0] a);
    return int'(a[1:0]) - (int'(a[1:0]) % n);
  endfunction

  function automatic logic [3:0] be_of(input bit ld, input logic [2:0] f3, input logic [31:0] a);
    int n = size_of(ld, f3);
    return 4'(((1 << n) - 1) << off_of(n, a));
  endfunction

  function automatic logic [31:0] wd_of(input bit ld, input logic [2:0] f3, input logic [31:0] wd);
    int n = size_of(ld, f3);
    if (n == 1) return {24'd0, wd[7:0]} * 32'h0101_0101;
    if (n == 2) return {16'd0, wd[15:0]} * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] load_of(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] bus);
    int n = size_of(1'b1, f3);
    logic [31:0] v, mask;
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    v = (bus >> (8 * off_of(n, a))) & mask;
    if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("enable_out", 32'(enable_out), exp_pass ? 32'(enable_in) : 32'd0);
      chk("enable_pc_out", 32'(enable_pc_out), (exp_pass && enable_pc_in) ? 32'd1 : 32'd0);
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("avm_read", 32'(avm_read), 32'(exp_rd));
      chk("avm_write", 32'(avm_write), 32'(exp_wr));
      chk("err", 32'(err), 32'(exp_err));
      chk("rdata", rdata, rdata_m);
      if (exp_rd || exp_wr) begin
        chk("avm_address", avm_address, exp_addr);
        chk("avm_byteenable", 32'(avm_byteenable), 32'(exp_be));
        if (exp_wr) chk("avm_writedata", avm_writedata, exp_wd);
      end
    end
    if (avm_read || avm_write) begin
      last_addr = avm_address;
      last_be   = avm_byteenable;
      last_wd   = avm_writedata;
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      mem_rd = 1'b0; mem_wr = 1'b0;
      avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = $urandom;
      enable_in = 4'($urandom); enable_pc_in = 1'($urandom);
      exp_pass = 1'b1; exp_busy = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0; exp_err = 1'b0;
      chk_en = 1'b1;
      @(posedge CLK); #1;
    end
  endtask

  // Timeline model: cycle 0 = request presented, strobes from cycle 1, DONE at 'done'.
  task automatic access(input bit ld, input bit both, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] bus, input int wait_n, input int rdv_dly);
    int n, s_end, done, rdv_cyc;
    bit trap, to;
    n = size_of(ld, f3);
    trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
`endif
    to = 1'b0;
    rdv_cyc = -1;
    if (trap) begin
      s_end = 0; done = 1;
    end else if (wait_n >= TIMEOUT) begin
      s_end = TIMEOUT; done = TIMEOUT + 1; to = 1'b1;
    end else begin
      s_end = 1 + wait_n;
      if (!ld) done = s_end + 1;
      else if (rdv_dly < 0 || rdv_dly >= TIMEOUT) begin
        done = s_end + 1 + TIMEOUT; to = 1'b1;
      end else begin
        rdv_cyc = s_end + 1 + rdv_dly; done = rdv_cyc + 1;
      end
    end
    for (int k = 0; k <= done; k++) begin
      mem_rd = ld; mem_wr = !ld || both;
      funct3 = f3; addr = a; wdata = wd;
      enable_in = 4'($urandom); enable_pc_in = 1'($urandom);
      avm_waitrequest   = (k >= 1 && k < 1 + wait_n);
      avm_readdatavalid = (k == rdv_cyc) || (ld && k >= 1 && k < s_end);
      avm_readdata      = (k == rdv_cyc) ? bus : $urandom;
      exp_pass = (k == done);
      exp_busy = (k >= 1);
      exp_rd   = !trap && ld && k >= 1 && k <= s_end;
      exp_wr   = !trap && !ld && k >= 1 && k <= s_end;
      exp_err  = (k == done) && (trap || to);
      exp_addr = {a[31:2], 2'b00};
      exp_be   = be_of(ld, f3, a);
      exp_wd   = wd_of(ld, f3, wd);
      if (k == done && ld) rdata_m = trap ? 32'd0 : (to ? 32'hFFFF_FFFF : load_of(f3, a, bus));
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    mem_rd = 1'b0; mem_wr = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;
    enable_in = 4'hA; enable_pc_in = 1'b1;
    avm_readdata = '0; avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
    rdata_m = 32'd0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_avm_read", 32'(avm_read), 32'd0);
    chk("rst_avm_write", 32'(avm_write), 32'd0);
    chk("rst_byteenable", 32'(avm_byteenable), 32'd0);
    chk("rst_address", avm_address, 32'd0);
    chk("rst_writedata", avm_writedata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_enable_out", 32'(enable_out), 32'hA);
    RST_N = 1'b1;
    idle(2);

    access(1'b0, 1'b0, F3_W, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 0);
    chk("sw_be_lit", 32'(last_be), 32'hF);
    chk("sw_wd_lit", last_wd, 32'hDEAD_BEEF);
    chk("sw_addr_lit", last_addr, 32'h100);
    idle(1);
    access(1'b1, 1'b0, F3_B, 32'h103, 32'h0, 32'h80FF_FF00, 0, 0);
    chk("lb_lit", rdata, 32'hFFFF_FF80);
    idle(1);
    access(1'b1, 1'b0, F3_BU, 32'h103, 32'h0, 32'h80FF_FF00, 0, 0);
    chk("lbu_lit", rdata, 32'h0000_0080);
    idle(1);
    access(1'b0, 1'b0, F3_H, 32'h102, 32'h0000_1234, 32'h0, 3, 0);
    chk("sh_be_lit", 32'(last_be), 32'hC);
    chk("sh_wd_lit", last_wd, 32'h1234_1234);
    idle(1);
    access(1'b1, 1'b0, F3_H, 32'h102, 32'h0, 32'h8001_7FFF, 1, 2);
    chk("lh_lit", rdata, 32'hFFFF_8001);
    idle(1);
    access(1'b1, 1'b0, F3_HU, 32'h100, 32'h0, 32'h1234_ABCD, 0, 1);
    chk("lhu_lit", rdata, 32'h0000_ABCD);
    idle(1);
    access(1'b0, 1'b0, F3_B, 32'h101, 32'h0000_00A5, 32'h0, 0, 0);
    chk("sb_be_lit", 32'(last_be), 32'h2);
    idle(1);
    access(1'b1, 1'b1, F3_W, 32'h104, 32'h1111_1111, 32'hCAFE_F00D, 2, 3);
    chk("rdwr_as_load_lit", rdata, 32'hCAFE_F00D);
    idle(1);
    access(1'b1, 1'b0, F3_W, 32'h108, 32'h0, 32'h0, 0, -1);
    chk("rd_timeout_lit", rdata, 32'hFFFF_FFFF);
    idle(1);
    access(1'b0, 1'b0, F3_W, 32'h10C, 32'h7777_7777, 32'h0, 20, 0);
    idle(1);
    access(1'b1, 1'b0, 3'b011, 32'h10C, 32'h0, 32'h1122_3344, 0, 0);
    chk("rsvd_load_lit", rdata, 32'h1122_3344);
    idle(1);
    access(1'b0, 1'b0, 3'b111, 32'h110, 32'h5566_7788, 32'h0, 0, 0);
    chk("rsvd_store_be_lit", 32'(last_be), 32'hF);
    idle(1);
    access(1'b1, 1'b0, F3_W, 32'h101, 32'h0, 32'h0BAD_F00D, 0, 0);
`ifdef MISALIGN_TRAP_EN
    chk("misalign_trap_rdata_lit", rdata, 32'd0);
`else
    chk("misalign_rdata_lit", rdata, 32'h0BAD_F00D);
    chk("misalign_addr_lit", last_addr, 32'h100);
    chk("misalign_be_lit", 32'(last_be), 32'hF);
`endif
    idle(1);
    access(1'b0, 1'b0, F3_H, 32'h103, 32'h0000_BEEF, 32'h0, 0, 0);
    idle(1);

    chk_en = 1'b0;
    mem_wr = 1'b1; mem_rd = 1'b0; funct3 = F3_H; addr = 32'h102; wdata = 32'h9999;
    avm_waitrequest = 1'b1;
    @(posedge CLK); #1;
    chk("rst_req_write_pre", 32'(avm_write), 32'd1);
    #2 RST_N = 1'b0;
    #1;
    chk("rst_req_write_drop", 32'(avm_write), 32'd0);
    chk("rst_req_busy", 32'(busy), 32'd0);
    mem_wr = 1'b0; avm_waitrequest = 1'b0;
    @(posedge CLK); #1 RST_N = 1'b1;

    mem_rd = 1'b1; funct3 = F3_W; addr = 32'h200;
    @(posedge CLK); #1;
    chk("rst_rd_read_pre", 32'(avm_read), 32'd1);
    @(posedge CLK); #1;
    chk("rst_rdwait_busy_pre", 32'(busy), 32'd1);
    #2 RST_N = 1'b0;
    #1;
    chk("rst_rdwait_busy", 32'(busy), 32'd0);
    chk("rst_rdwait_read", 32'(avm_read), 32'd0);
    mem_rd = 1'b0;
    @(posedge CLK); #1 RST_N = 1'b1;
    avm_readdatavalid = 1'b1; avm_readdata = 32'h1234_5678;
    @(posedge CLK); #1 avm_readdatavalid = 1'b0;
    chk("rst_no_stale_rdata", rdata, 32'd0);
    chk("rst_after_busy", 32'(busy), 32'd0);
    rdata_m = 32'd0;
    idle(2);
    access(1'b1, 1'b0, F3_BU, 32'h201, 32'h0, 32'h0000_5A00, 0, 0);
    chk("post_rst_lbu_lit", rdata, 32'h0000_005A);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/avalon_data_port.md
# avalon_data_port

Parametrised data-memory port for the pipelined RV32 core: replaces the fixed-width read/write strobe controllers with one Avalon-MM master supporting byte/halfword/word access, waitrequest and pipelined reads. Sits between the EX/MEM register outputs and the data bus. It gates the per-stage pipeline enables and the PC enable until each access completes. It returns load data already lane-aligned and sign/zero-extended for the MEM/WB register.

## Interface
Parameters:
- ADDR_W, 32, Avalon byte-address width.
- N_STAGES, 4, number of pipeline-register enables gated.
- TIMEOUT, 0, maximum cycles spent waiting in REQ or RDWAIT; 0 disables the watchdog.

Ports:
- CLK  in  1  clock; single clock domain.
- RST_N  in  1  asynchronous, active-low reset.
- mem_rd  in  1  load request (level) from EX/MEM.
- mem_wr  in  1  store request (level); mem_rd and mem_wr both high counts as a load.
- funct3  in  3  access size and sign.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data, low bits significant.
- enable_in  in  N_STAGES  upstream stage enables.
- enable_pc_in  in  1  upstream PC enable.
- enable_out  out  N_STAGES  gated stage enables.
- enable_pc_out  out  1  gated PC enable.
- rdata  out  32  extended load data, held until the next load completes.
- busy  out  1  FSM not in IDLE.
- err  out  1  one-cycle pulse on timeout (or on misalign when MISALIGN_TRAP_EN is defined).
- avm_address  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00}).
- avm_read  out  1  Avalon read.
- avm_write  out  1  Avalon write.
- avm_byteenable  out  4  Avalon byte enables.
- avm_writedata  out  32  Avalon write data.
- avm_readdata  in  32  Avalon read data.
- avm_waitrequest  in  1  Avalon wait.
- avm_readdatavalid  in  1  Avalon read data valid.

## Operation
States and transitions:
- IDLE: moves to REQ when a request is present.
- REQ: holds avm_read or avm_write and the registered address, byteenable and writedata stable while waitrequest=1. On acceptance, a read goes to RDWAIT and a write goes to DONE.
- RDWAIT: on readdatavalid, registers extended data into rdata and goes to DONE.
- DONE: passes enables through for one cycle, then returns to IDLE. A request seen in DONE is not re-issued.

Enable gating:
- enable_out = enable_in and enable_pc_out = enable_pc_in only in DONE, or in IDLE with no request.
- Otherwise (IDLE with a request, REQ, RDWAIT) both are forced to 0.

Byte enables:
- SB: 4'b0001<<addr[1:0].
- SH: 4'b0011<<{addr[1],1'b0}.
- SW: 4'b1111.
- writedata replicates the byte or halfword across lanes.

Loads:
- funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Lane selected by addr[1:0].
- Reserved funct3 codes execute as LW/SW.

Watchdog (TIMEOUT>0):
- Counter resets on entry to REQ or RDWAIT.
- At TIMEOUT cycles: drop the strobe, pulse err, set rdata=32'hFFFF_FFFF for a read, go to DONE.

## Timing
- Reset values: all avm strobes 0, byteenable 0, address 0, writedata 0, rdata 0, busy 0, err 0, state IDLE.
- Reset mid-access drops the strobes immediately; the access is abandoned.
- Zero-wait write: request in cycle 0, strobe in cycle 1, DONE in cycle 2. The pipeline stalls 2 cycles.
- Zero-wait load with readdatavalid one cycle after acceptance: strobe in cycle 1, data in cycle 2, DONE in cycle 3. rdata is valid from cycle 3.
- readdatavalid arriving in REQ is ignored; a single outstanding transaction is assumed.
- err is registered and coincides with DONE.

## Configuration
- MISALIGN_TRAP_EN defined: a halfword with addr[0]=1, or a word with addr[1:0]≠0, is not issued. IDLE goes directly to DONE, err pulses, and a load returns rdata=0.
- MISALIGN_TRAP_EN undefined: the offending low address bits are forced to 0 (aligned to the access size), the access proceeds normally, and err is driven only by the watchdog.

## Structure
- Shared package dport_pkg holds:
  - the state enum {IDLE, REQ, RDWAIT, DONE}
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU
  - the error-fill constant 32'hFFFF_FFFF.
- Sub-module load_align: combinational lane select plus sign/zero extension, and the byteenable/writedata store lane generator.

## Test plan
- SW at addr 0x100, wdata 0xDEADBEEF, waitrequest 0 → byteenable 4'hF, write in cycle 1, enable_out returns to enable_in in cycle 2.
- LB at addr 0x103, readdata 0x80FF_FF00 → rdata 0xFFFF_FF80; LBU same → 0x0000_0080.
- SH at addr 0x102, wdata 0x1234, waitrequest high for 3 cycles → strobe and payload stable, byteenable 4'b1100, writedata 0x1234_1234, DONE 1 cycle after release.
- TIMEOUT=8, LW with readdatavalid never asserted → err pulse 10 cycles after the request, rdata 0xFFFF_FFFF, pipeline resumes.
- RST_N low during RDWAIT → strobes 0 and busy 0 asynchronously; no stale rdata update when readdatavalid arrives after reset release.
- MISALIGN_TRAP_EN with LW at 0x101 → no avm_read, err pulse cycle 1, rdata 0; without the macro → read at 0x100 with byteenable 4'hF.
